// File: rtl/raster_setup_sched.sv
// Schedules frame and per-line edge-setup commands on a shared setup engine and
// holds the returned edge initialisers for the two triangles of the next scanline.
module raster_setup_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        setup_req,
    input  logic        setup_ack,
    output logic        setup_frame,
    output logic        setup_tri,
    output logic [9:0]  setup_line,
    input  logic [59:0] res_e,
    output logic [59:0] e_init_t1,
    output logic [59:0] e_init_t2,
    output logic        underrun,
    output logic        frame_ready
);

    typedef enum logic [2:0] {StIdle, StFReq, StLReq0, StLReq1, StDone} state_e;

    state_e      state_q, state_d;
    logic        gap_q;
    logic        frame_pend_q, frame_pend_d;
    logic [9:0]  line_q, line_d;
    logic        underrun_q;
    logic        frame_ready_q;
    logic [59:0] e_t1_q, e_t2_q;
    logic [59:0] shadow_t1_q, shadow_t2_q;
    logic        pend_t1_q, pend_t2_q;

    logic        frame_trig, line_trig, end_of_line, blank, busy, ack_ok;
    logic        start_frame, wr_t1, wr_t2;
    logic [9:0]  line_tgt;

    assign frame_trig  = (y == 10'd480) && (x == 10'd0);
    assign line_trig   = (x == 10'd640) && ((y <= 10'd478) || (y == 10'd524));
    assign line_tgt    = (y == 10'd524) ? 10'd0 : y + 10'd1;
    assign end_of_line = (x == 10'd799);
    assign blank       = (x >= 10'd640) || (y >= 10'd480);
    assign busy        = state_q inside {StFReq, StLReq0, StLReq1};

    // The cycle right after an accepted ack is forced idle so commands never merge.
    assign setup_req   = busy && !gap_q;
    assign ack_ok      = setup_ack && setup_req;
    assign wr_t1       = ack_ok && (state_q == StLReq0);
    assign wr_t2       = ack_ok && (state_q == StLReq1);

    assign setup_frame = (state_q == StFReq);
    assign setup_tri   = (state_q == StLReq1);
    assign setup_line  = line_q;
    assign e_init_t1   = e_t1_q;
    assign e_init_t2   = e_t2_q;
    assign underrun    = underrun_q;
    assign frame_ready = frame_ready_q;

    always_comb begin
        state_d      = state_q;
        frame_pend_d = frame_pend_q;
        line_d       = line_q;
        start_frame  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (frame_trig || frame_pend_q) begin
                    state_d      = StFReq;
                    frame_pend_d = 1'b0;
                    start_frame  = 1'b1;
                end else if (line_trig) begin
                    state_d = StLReq0;
                    line_d  = line_tgt;
                end else if ((state_q == StDone) && end_of_line) begin
                    state_d = StIdle;
                end
            end
            StFReq:  if (ack_ok) state_d = StIdle;
            StLReq0: if (ack_ok) state_d = StLReq1;
            StLReq1: if (ack_ok) state_d = StDone;
            default: state_d = StIdle;
        endcase
        if (busy && frame_trig) frame_pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            gap_q         <= 1'b0;
            frame_pend_q  <= 1'b0;
            line_q        <= '0;
            underrun_q    <= 1'b0;
            frame_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= ack_ok;
            frame_pend_q <= frame_pend_d;
            line_q       <= line_d;
            if ((state_q == StLReq0 || state_q == StLReq1) && end_of_line) underrun_q <= 1'b1;
            if (start_frame) begin
                frame_ready_q <= 1'b0;
            end else if (ack_ok && (state_q == StFReq)) begin
                frame_ready_q <= 1'b1;
            end
        end
    end

    // Late results arriving in the active area are parked and committed at the next blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_t1_q      <= '0;
            e_t2_q      <= '0;
            shadow_t1_q <= '0;
            shadow_t2_q <= '0;
            pend_t1_q   <= 1'b0;
            pend_t2_q   <= 1'b0;
        end else begin
            if (wr_t1) begin
                if (blank) begin
                    e_t1_q    <= res_e;
                    pend_t1_q <= 1'b0;
                end else begin
                    shadow_t1_q <= res_e;
                    pend_t1_q   <= 1'b1;
                end
            end else if (pend_t1_q && blank) begin
                e_t1_q    <= shadow_t1_q;
                pend_t1_q <= 1'b0;
            end
            if (wr_t2) begin
                if (blank) begin
                    e_t2_q    <= res_e;
                    pend_t2_q <= 1'b0;
                end else begin
                    shadow_t2_q <= res_e;
                    pend_t2_q   <= 1'b1;
                end
            end else if (pend_t2_q && blank) begin
                e_t2_q    <= shadow_t2_q;
                pend_t2_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_raster_setup_sched.sv
// Self-checking bench for raster_setup_sched: a behavioural setup engine answers
// requests with random results, and a scoreboard predicts the stored edge values.
module tb_raster_setup_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        setup_req, setup_ack, setup_frame, setup_tri;
    logic [9:0]  setup_line;
    logic [59:0] res_e, e_init_t1, e_init_t2;
    logic        underrun, frame_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Engine model state
    bit          eng_en = 1'b0;
    bit          eng_fixed_on = 1'b0;
    bit          stray = 1'b0;
    int          eng_delay = 1;
    int          eng_cnt = 0;
    int          eng_n = 0;
    logic [59:0] eng_res [8];
    logic [59:0] eng_fixed [2];
    logic [59:0] exp_t1 = '0;
    logic [59:0] exp_t2 = '0;

    raster_setup_sched dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .setup_req   (setup_req),
        .setup_ack   (setup_ack),
        .setup_frame (setup_frame),
        .setup_tri   (setup_tri),
        .setup_line  (setup_line),
        .res_e       (res_e),
        .e_init_t1   (e_init_t1),
        .e_init_t2   (e_init_t2),
        .underrun    (underrun),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [59:0] rand60();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[59:0];
    endfunction

    // One pixel clock: outputs are sampled 1 time unit after the edge, then the
    // VGA counters advance and the engine decides whether to ack this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (x == 10'd799) begin
            x = 10'd0;
            y = (y == 10'd524) ? 10'd0 : y + 10'd1;
        end else begin
            x = x + 10'd1;
        end
        setup_ack = 1'b0;
        res_e     = rand60();
        if (stray) begin
            setup_ack = 1'b1;
        end else if (eng_en && setup_req) begin
            eng_cnt++;
            if (eng_cnt >= eng_delay) begin
                setup_ack = 1'b1;
                res_e = (eng_fixed_on && eng_n < 2) ? eng_fixed[eng_n] : rand60();
                if (eng_n < 8) eng_res[eng_n] = res_e;
                eng_n++;
                eng_cnt = 0;
            end
        end else begin
            eng_cnt = 0;
        end
    endtask

    task automatic goto(input int yy, input int xx);
        y = 10'(yy);
        x = 10'(xx);
    endtask

    task automatic run_to(input int yy, input int xx);
        int n = 0;
        while (!(y == 10'(yy) && x == 10'(xx)) && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) begin
            n_tests++; n_fail++;
            $display("FAIL run_to timeout: at y=%0d x=%0d want y=%0d x=%0d", y, x, yy, xx);
        end
    endtask

    task automatic wait_ack(input int bound);
        int n = 0;
        while (setup_ack !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        n_tests++;
        if (setup_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_ack: no ack within %0d cycles", bound);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; x = '0; y = '0; setup_ack = 1'b0; res_e = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (setup_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", setup_req); end
        n_tests++; if (setup_frame !== 1'b0) begin n_fail++; $display("FAIL rst_frame: got %b want 0", setup_frame); end
        n_tests++; if (setup_tri !== 1'b0) begin n_fail++; $display("FAIL rst_tri: got %b want 0", setup_tri); end
        n_tests++; if (setup_line !== 10'd0) begin n_fail++; $display("FAIL rst_line: got %0d want 0", setup_line); end
        n_tests++; if (e_init_t1 !== 60'd0) begin n_fail++; $display("FAIL rst_t1: got %h want 0", e_init_t1); end
        n_tests++; if (e_init_t2 !== 60'd0) begin n_fail++; $display("FAIL rst_t2: got %h want 0", e_init_t2); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        n_tests++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL rst_frame_ready: got %b want 0", frame_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_frame();
        eng_en = 1'b0;
        goto(480, 0);
        tick();
        // The request is visible in the cycle after the trigger cycle.
        n_tests++; if (setup_req !== 1'b1) begin n_fail++; $display("FAIL frame_req: got %b want 1", setup_req); end
        n_tests++; if (setup_frame !== 1'b1) begin n_fail++; $display("FAIL frame_cmd: got %b want 1", setup_frame); end
        n_tests++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL frame_ready_busy: got %b want 0", frame_ready); end
        eng_delay = 5; eng_n = 0; eng_en = 1'b1;
        wait_ack(20);
        tick();
        eng_en = 1'b0;
        n_tests++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL frame_ready: got %b want 1", frame_ready); end
        n_tests++; if (setup_req !== 1'b0) begin n_fail++; $display("FAIL frame_req_drop: got %b want 0", setup_req); end
    endtask

    task automatic test_line();
        eng_fixed[0] = 60'h00001_00002_00003;
        eng_fixed[1] = 60'h0000A_0000B_0000C;
        goto(10, 630);
        eng_fixed_on = 1'b1; eng_delay = 20; eng_n = 0; eng_en = 1'b1;
        run_to(10, 641);
        n_tests++; if (setup_line !== 10'd11) begin n_fail++; $display("FAIL line_tgt: got %0d want 11", setup_line); end
        n_tests++; if (setup_req !== 1'b1) begin n_fail++; $display("FAIL line_req: got %b want 1", setup_req); end
        n_tests++; if (setup_tri !== 1'b0) begin n_fail++; $display("FAIL line_tri0: got %b want 0", setup_tri); end
        n_tests++; if (setup_frame !== 1'b0) begin n_fail++; $display("FAIL line_frame: got %b want 0", setup_frame); end
        wait_ack(100);
        tick();
        n_tests++; if (setup_req !== 1'b0) begin n_fail++; $display("FAIL line_gap: got %b want 0", setup_req); end
        n_tests++; if (setup_tri !== 1'b1) begin n_fail++; $display("FAIL line_tri1: got %b want 1", setup_tri); end
        run_to(10, 700);
        eng_fixed_on = 1'b0; eng_en = 1'b0;
        exp_t1 = 60'h00001_00002_00003;
        exp_t2 = 60'h0000A_0000B_0000C;
        n_tests++; if (e_init_t1 !== exp_t1) begin n_fail++; $display("FAIL line_t1: got %h want %h", e_init_t1, exp_t1); end
        n_tests++; if (e_init_t2 !== exp_t2) begin n_fail++; $display("FAIL line_t2: got %h want %h", e_init_t2, exp_t2); end
        n_tests++; if (setup_req !== 1'b0) begin n_fail++; $display("FAIL line_done: got %b want 0", setup_req); end
    endtask

    task automatic test_line0();
        goto(524, 630);
        eng_delay = 3; eng_n = 0; eng_en = 1'b1;
        run_to(524, 641);
        n_tests++; if (setup_line !== 10'd0) begin n_fail++; $display("FAIL line0_tgt: got %0d want 0", setup_line); end
        run_to(524, 760);
        eng_en = 1'b0;
        exp_t1 = eng_res[0]; exp_t2 = eng_res[1];
        n_tests++; if (e_init_t2 !== exp_t2) begin n_fail++; $display("FAIL line0_t2: got %h want %h", e_init_t2, exp_t2); end
    endtask

    task automatic test_random_lines();
        for (int i = 0; i < 10; i++) begin
            int yy;
            logic [9:0] want_line;
            yy = ($urandom_range(0, 4) == 0) ? 524 : int'($urandom_range(0, 478));
            want_line = (yy == 524) ? 10'd0 : 10'(yy + 1);
            goto(yy, 630);
            eng_delay = int'($urandom_range(1, 40)); eng_n = 0; eng_en = 1'b1;
            run_to(yy, 760);
            eng_en = 1'b0;
            exp_t1 = eng_res[0]; exp_t2 = eng_res[1];
            n_tests++; if (setup_line !== want_line) begin n_fail++; $display("FAIL rnd_line[%0d]: got %0d want %0d", i, setup_line, want_line); end
            n_tests++; if (e_init_t1 !== exp_t1) begin n_fail++; $display("FAIL rnd_t1[%0d]: got %h want %h", i, e_init_t1, exp_t1); end
            n_tests++; if (e_init_t2 !== exp_t2) begin n_fail++; $display("FAIL rnd_t2[%0d]: got %h want %h", i, e_init_t2, exp_t2); end
            n_tests++; if (eng_n !== 2) begin n_fail++; $display("FAIL rnd_acks[%0d]: got %0d want 2", i, eng_n); end
            n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rnd_underrun[%0d]: got %b want 0", i, underrun); end
        end
    endtask

    task automatic test_stray_ack();
        // First stray lands in DONE, second in IDLE after the end of line.
        stray = 1'b1; tick(); stray = 1'b0; tick();
        n_tests++; if (e_init_t1 !== exp_t1) begin n_fail++; $display("FAIL stray_done_t1: got %h want %h", e_init_t1, exp_t1); end
        run_to(0, 10);
        stray = 1'b1; tick(); stray = 1'b0; tick();
        n_tests++; if (e_init_t1 !== exp_t1) begin n_fail++; $display("FAIL stray_idle_t1: got %h want %h", e_init_t1, exp_t1); end
        n_tests++; if (e_init_t2 !== exp_t2) begin n_fail++; $display("FAIL stray_idle_t2: got %h want %h", e_init_t2, exp_t2); end
        n_tests++; if (setup_req !== 1'b0) begin n_fail++; $display("FAIL stray_req: got %b want 0", setup_req); end
    endtask

    task automatic test_frame_pending();
        int n = 0;
        eng_en = 1'b0;
        goto(478, 639);
        run_to(478, 642);
        goto(480, 0);
        tick();
        n_tests++; if (setup_frame !== 1'b0) begin n_fail++; $display("FAIL pend_busy_frame: got %b want 0", setup_frame); end
        n_tests++; if (setup_req !== 1'b1) begin n_fail++; $display("FAIL pend_busy_req: got %b want 1", setup_req); end
        eng_delay = 2; eng_n = 0; eng_en = 1'b1;
        while (setup_frame !== 1'b1 && n < 50) begin tick(); n++; end
        n_tests++; if (eng_n !== 2) begin n_fail++; $display("FAIL pend_order: got %0d line acks want 2", eng_n); end
        n_tests++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL pend_ready_low: got %b want 0", frame_ready); end
        exp_t1 = eng_res[0]; exp_t2 = eng_res[1];
        wait_ack(20);
        tick();
        eng_en = 1'b0;
        n_tests++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL pend_ready: got %b want 1", frame_ready); end
        n_tests++; if (e_init_t2 !== exp_t2) begin n_fail++; $display("FAIL pend_t2: got %h want %h", e_init_t2, exp_t2); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL pend_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_underrun();
        eng_en = 1'b0;
        goto(20, 630);
        run_to(20, 799);
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_early: got %b want 0", underrun); end
        tick();
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_set: got %b want 1", underrun); end
        // Late acks in the active area must not disturb the visible values yet.
        eng_delay = 3; eng_n = 0; eng_en = 1'b1;
        run_to(21, 100);
        eng_en = 1'b0;
        n_tests++; if (eng_n !== 2) begin n_fail++; $display("FAIL ur_acks: got %0d want 2", eng_n); end
        n_tests++; if (e_init_t1 !== exp_t1) begin n_fail++; $display("FAIL ur_hold_t1: got %h want %h", e_init_t1, exp_t1); end
        n_tests++; if (e_init_t2 !== exp_t2) begin n_fail++; $display("FAIL ur_hold_t2: got %h want %h", e_init_t2, exp_t2); end
        run_to(21, 641);
        exp_t1 = eng_res[0]; exp_t2 = eng_res[1];
        n_tests++; if (e_init_t1 !== exp_t1) begin n_fail++; $display("FAIL ur_late_t1: got %h want %h", e_init_t1, exp_t1); end
        n_tests++; if (e_init_t2 !== exp_t2) begin n_fail++; $display("FAIL ur_late_t2: got %h want %h", e_init_t2, exp_t2); end
        n_tests++; if (setup_line !== 10'd22) begin n_fail++; $display("FAIL ur_next_line: got %0d want 22", setup_line); end
        // Engine stays silent, so the line-22 trigger meets a busy FSM and is dropped.
        run_to(22, 641);
        n_tests++; if (setup_line !== 10'd22) begin n_fail++; $display("FAIL ur_drop: got %0d want 22", setup_line); end
        n_tests++; if (setup_req !== 1'b1) begin n_fail++; $display("FAIL ur_wait: got %b want 1", setup_req); end
        eng_delay = 2; eng_n = 0; eng_en = 1'b1;
        run_to(22, 700);
        eng_en = 1'b0;
        exp_t1 = eng_res[0]; exp_t2 = eng_res[1];
        n_tests++; if (e_init_t2 !== exp_t2) begin n_fail++; $display("FAIL ur_final_t2: got %h want %h", e_init_t2, exp_t2); end
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_sticky: got %b want 1", underrun); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int seen = 0;
        goto(30, 635);
        eng_delay = 2; eng_n = 0; eng_en = 1'b1;
        while (eng_n < 1 && n < 50) begin tick(); n++; end
        eng_en = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_tests++; if (setup_req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %b want 0", setup_req); end
        n_tests++; if (setup_tri !== 1'b0) begin n_fail++; $display("FAIL rm_tri: got %b want 0", setup_tri); end
        n_tests++; if (setup_line !== 10'd0) begin n_fail++; $display("FAIL rm_line: got %0d want 0", setup_line); end
        n_tests++; if (e_init_t1 !== 60'd0) begin n_fail++; $display("FAIL rm_t1: got %h want 0", e_init_t1); end
        n_tests++; if (e_init_t2 !== 60'd0) begin n_fail++; $display("FAIL rm_t2: got %h want 0", e_init_t2); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rm_underrun: got %b want 0", underrun); end
        n_tests++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready: got %b want 0", frame_ready); end
        repeat (3) tick();
        reset = 1'b0;
        goto(40, 600);
        eng_delay = 4; eng_n = 0; eng_en = 1'b1;
        while (x != 10'd641) begin
            tick();
            if (x <= 10'd640 && setup_req === 1'b1) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rm_quiet: got %0d req cycles want 0", seen); end
        n_tests++; if (setup_line !== 10'd41) begin n_fail++; $display("FAIL rm_resume_line: got %0d want 41", setup_line); end
        n_tests++; if (setup_req !== 1'b1) begin n_fail++; $display("FAIL rm_resume_req: got %b want 1", setup_req); end
        run_to(40, 760);
        eng_en = 1'b0;
        n_tests++; if (e_init_t1 !== eng_res[0]) begin n_fail++; $display("FAIL rm_resume_t1: got %h want %h", e_init_t1, eng_res[0]); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_line();
        test_random_lines();
        test_line0();
        test_stray_ack();
        test_frame_pending();
        test_underrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/raster_setup_sched.md
RASTER_SETUP_SCHED -- requirements
Module: raster_setup_sched

Interface
REQ-001 clk  input  1  pixel clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 x, y  input  10 each  VGA counters; 800x525 total, 640x480 visible.
REQ-004 setup_req  output  1  request to the shared edge-setup engine.
REQ-005 setup_ack  input  1  one-cycle engine completion strobe; result buses valid in the same cycle.
REQ-006 setup_frame  output  1  1 = frame setup command, 0 = line setup command; valid while setup_req=1.
REQ-007 setup_tri  output  1  triangle select (0 = tri 1, 1 = tri 2) for line commands.
REQ-008 setup_line  output  10  target scanline for line commands.
REQ-009 res_e  input  60  engine result {e2,e1,e0}, each signed int20.
REQ-010 e_init_t1, e_init_t2  output  60 each  registered {e2,e1,e0} per triangle, fed to the rasterizer's e*_init ports.
REQ-011 underrun  output  1  sticky; set when a line setup misses its deadline.
REQ-012 frame_ready  output  1  high after frame setup is acknowledged; low from frame command issue until its ack.

Function
REQ-013 States: IDLE, F_REQ, L_REQ0, L_REQ1, DONE.
REQ-014 IDLE -> F_REQ on the cycle (y==480, x==0); setup_req=1 and setup_frame=1 in F_REQ.
REQ-015 F_REQ -> IDLE on setup_ack; frame_ready set that cycle; no outputs written.
REQ-016 Line trigger: (x==640, y<=478) targets line y+1; (x==640, y==524) targets line 0.
REQ-017 On a line trigger in IDLE or DONE -> L_REQ0; setup_line latched; setup_tri=0.
REQ-018 L_REQ0: on setup_ack, res_e is written to e_init_t1 and the state moves to L_REQ1 with setup_tri=1.
REQ-019 L_REQ1: on setup_ack, res_e is written to e_init_t2 and the state moves to DONE.
REQ-020 DONE -> IDLE on (x==799).
REQ-021 setup_req is high in F_REQ, L_REQ0 and L_REQ1 only, and stays high until ack; no request is withdrawn.
REQ-022 setup_req drops in the cycle after the ack and is low for at least one cycle between commands.
REQ-023 A setup_ack received while in IDLE or DONE is ignored.
REQ-024 Deadline: if the state is L_REQ0 or L_REQ1 at (x==799), underrun is set.
REQ-025 After a deadline miss the FSM keeps waiting for the ack.
REQ-026 A line trigger arriving while in L_REQ0, L_REQ1 or F_REQ is dropped.
REQ-027 After a deadline miss, the outputs written late remain valid for the following line.
REQ-028 Simultaneous frame trigger and busy state: the frame trigger is held pending and serviced from IDLE or DONE before any later line trigger.
REQ-029 e_init outputs change only in hblank (x>=640) or vblank; they are never written while x<640 and y<480.
REQ-030 Results pass through unmodified; no arithmetic is performed on res_e.

Reset
REQ-031 On reset: state=IDLE, setup_req=0, setup_frame=0, setup_tri=0, setup_line=0.
REQ-032 On reset: e_init_t1=0, e_init_t2=0, underrun=0, frame_ready=0, frame pending=0.
REQ-033 Reset asserted mid-handshake aborts the command; the first command after release is the next trigger.

Verification
REQ-034 Frame: at y=480, x=0 the bench sees setup_req=1 and setup_frame=1; ack after 5 cycles -> frame_ready=1 and setup_req=0 the next cycle.
REQ-035 Line: at y=10, x=640, ack each command after 20 cycles with res_e=0x00001_00002_00003, then 0x0000A_0000B_0000C -> setup_line=11; e_init_t1 and e_init_t2 hold those values by x=683; state DONE.
REQ-036 Line 0 setup: at y=524, x=640 the bench sees setup_line=0.
REQ-037 Underrun: withhold the ack until x=799 of line 20 -> underrun=1; the late ack still writes e_init_t2; the line-21 trigger is dropped only if the FSM is still busy.
REQ-038 Stray ack in IDLE -> e_init outputs unchanged.
REQ-039 Reset pulse during L_REQ1 -> all outputs 0 within the cycle; normal sequencing resumes at the next x==640 trigger.
